// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-controller TX framer.
//   state_e  : framer FSM encoding
//   BYTE_W   : UART byte width
//   nbytes() : bytes per ALU result
//   cnt_w()  : minimum counter width able to hold 0..max_val
package sys_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  function automatic int nbytes(input int alu_w);
    return alu_w / BYTE_W;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sys_ctrl_req_hold.sv
// One-deep request holding register with pending flag.
//   clk, rst   : clock, async active-high reset
//   vld_i      : capture strobe for din_i
//   din_i      : request payload
//   consume_i  : the framer takes the held entry this edge
//   pend_o     : an entry is held
//   dout_o     : held payload
//   drop_o     : vld_i arrived while full and not being drained (combinational)
module sys_ctrl_req_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] din_i,
  input  logic         consume_i,
  output logic         pend_o,
  output logic [W-1:0] dout_o,
  output logic         drop_o
);

  logic         pend_q, pend_d;
  logic [W-1:0] data_q, data_d;
  logic         capture;

  // A consume on the same edge frees the slot, so the new value lands in it
  // and the flag stays set; a full, undrained slot keeps its old entry.
  always_comb begin
    capture = vld_i & (~pend_q | consume_i);
    pend_d  = capture | (pend_q & ~consume_i);
    data_d  = capture ? din_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend_o = pend_q;
  assign dout_o = data_q;
  assign drop_o = vld_i & pend_q & ~consume_i;

endmodule

// File: rtl/sys_ctrl_tx_framer.sv
// Frames register-file bytes and multi-byte ALU results onto a byte UART TX.
//   CLK, RST  : clock, async active-high reset
//   Rd_D/_VLD : register read byte and one-cycle valid
//   ALU_OUT/_VLD : ALU result and one-cycle valid
//   BUSY      : UART TX busy
//   TX_VLD    : one-cycle byte strobe, TX_IN : byte to send (held between strobes)
//   CTRL_BUSY : frame in progress or request pending
//   OVF       : one-cycle pulse when a request was dropped
module sys_ctrl_tx_framer
  import sys_ctrl_pkg::*;
#(
  parameter int ALU_W     = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] Rd_D,
  input  logic              Rd_D_VLD,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              ALU_VLD,
  input  logic              BUSY,
  output logic              TX_VLD,
  output logic [BYTE_W-1:0] TX_IN,
  output logic              CTRL_BUSY,
  output logic              OVF
);

  localparam int NB = nbytes(ALU_W);
  localparam int CW = cnt_w(NB);
  localparam int WW = cnt_w(TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [ALU_W-1:0]  shift_q, shift_d;
  logic              tx_vld_q, tx_vld_d;
  logic [BYTE_W-1:0] tx_in_q, tx_in_d;
  logic              ovf_q, ovf_d;

  logic              data_pend, alu_pend, data_take, alu_take, data_drop, alu_drop;
  logic [BYTE_W-1:0] data_hold;
  logic [ALU_W-1:0]  alu_hold;
  logic [BYTE_W-1:0] cur_byte;

  sys_ctrl_req_hold #(.W(BYTE_W)) u_data_hold (
    .clk(CLK), .rst(RST), .vld_i(Rd_D_VLD), .din_i(Rd_D), .consume_i(data_take),
    .pend_o(data_pend), .dout_o(data_hold), .drop_o(data_drop)
  );

  sys_ctrl_req_hold #(.W(ALU_W)) u_alu_hold (
    .clk(CLK), .rst(RST), .vld_i(ALU_VLD), .din_i(ALU_OUT), .consume_i(alu_take),
    .pend_o(alu_pend), .dout_o(alu_hold), .drop_o(alu_drop)
  );

  // The byte on the wire always sits at the end of the shift register that
  // is shifted out first, so one shift direction covers every later byte.
  assign cur_byte = LSB_FIRST ? shift_q[BYTE_W-1:0] : shift_q[ALU_W-1 -: BYTE_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    shift_d   = shift_q;
    data_take = 1'b0;
    alu_take  = 1'b0;
    // TX outputs are a register stage behind the ISSUE state; that stage is
    // what sets the three-edge request-to-strobe latency.
    tx_vld_d  = (state_q == ISSUE);
    tx_in_d   = (state_q == ISSUE) ? cur_byte : tx_in_q;
    ovf_d     = data_drop | alu_drop;

    case (state_q)
      IDLE: begin
        if (data_pend) begin
          data_take = 1'b1;
          shift_d   = LSB_FIRST ? ALU_W'(data_hold)
                                : (ALU_W'(data_hold) << (ALU_W - BYTE_W));
          cnt_d     = CW'(1);
          state_d   = ISSUE;
        end else if (alu_pend) begin
          alu_take = 1'b1;
          shift_d  = alu_hold;
          cnt_d    = CW'(NB);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (BUSY) begin
          state_d = WAIT_LO;
        end else if ((TIMEOUT > 0) && (wait_q == WW'(TIMEOUT - 1))) begin
          // UART never acknowledged: re-strobe the same byte.
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!BUSY) begin
          if (cnt_q > CW'(1)) begin
            cnt_d   = cnt_q - 1'b1;
            shift_d = LSB_FIRST ? (shift_q >> BYTE_W) : (shift_q << BYTE_W);
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      shift_q  <= '0;
      tx_vld_q <= 1'b0;
      tx_in_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      shift_q  <= shift_d;
      tx_vld_q <= tx_vld_d;
      tx_in_q  <= tx_in_d;
      ovf_q    <= ovf_d;
    end
  end

  assign TX_VLD    = tx_vld_q;
  assign TX_IN     = tx_in_q;
  assign OVF       = ovf_q;
  assign CTRL_BUSY = (state_q != IDLE) | data_pend | alu_pend;

endmodule

// File: tb/tb_sys_ctrl_tx_framer.sv
// Scoreboard bench for sys_ctrl_tx_framer. Three instances:
//   inst0: ALU_W=16, LSB first, TIMEOUT=4
//   inst1: ALU_W=32, LSB first, TIMEOUT=16
//   inst2: ALU_W=32, MSB first, TIMEOUT=16
// Stimulus pushes expected bytes; the negedge monitor pops one per TX_VLD.
module tb_sys_ctrl_tx_framer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_d     [NI];
  logic        rd_vld   [NI];
  logic [31:0] alu      [NI];
  logic        alu_vld  [NI];
  logic        busy     [NI] = '{1'b0, 1'b0, 1'b0};
  logic        tx_vld   [NI];
  logic [7:0]  tx_in    [NI];
  logic        ctrl_busy[NI];
  logic        ovf      [NI];

  logic [7:0]  exp_q [NI][$];
  int          checks = 0;
  int          errors = 0;
  int          ovf_cnt [NI] = '{0, 0, 0};
  int          bz_dly  [NI] = '{0, 0, 0};
  int          bz_hold [NI] = '{0, 0, 0};
  bit          bz_auto [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 16 : 32;
    sys_ctrl_tx_framer #(
      .ALU_W(W), .LSB_FIRST((g == 2) ? 1'b0 : 1'b1), .TIMEOUT((g == 0) ? 4 : 16)
    ) u_dut (
      .CLK(clk), .RST(rst), .Rd_D(rd_d[g]), .Rd_D_VLD(rd_vld[g]),
      .ALU_OUT(alu[g][W-1:0]), .ALU_VLD(alu_vld[g]), .BUSY(busy[g]),
      .TX_VLD(tx_vld[g]), .TX_IN(tx_in[g]), .CTRL_BUSY(ctrl_busy[g]), .OVF(ovf[g])
    );
  end

  // Monitor + UART BUSY model: BUSY rises two negedges after a strobe is seen
  // and stays high for 10 cycles.
  always @(negedge clk) begin
    logic [7:0] e;
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        busy[g]    = 1'b0;
        bz_dly[g]  = 0;
        bz_hold[g] = 0;
      end else begin
        if (ovf[g]) ovf_cnt[g]++;
        if (tx_vld[g]) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx inst%0d: got TX_IN=%02h, expected no strobe", g, tx_in[g]);
          end else begin
            e = exp_q[g].pop_front();
            if (tx_in[g] !== e) begin
              errors++;
              $display("FAIL tx_byte inst%0d: got %02h, expected %02h", g, tx_in[g], e);
            end
          end
          checks++;
          if (busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL issue_while_busy inst%0d: BUSY=%b at strobe, expected 0", g, busy[g]);
          end
        end
        if (bz_dly[g] > 0) begin
          bz_dly[g]--;
          if (bz_dly[g] == 0) begin
            busy[g]    = 1'b1;
            bz_hold[g] = 10;
          end
        end else if (bz_hold[g] > 0) begin
          bz_hold[g]--;
          if (bz_hold[g] == 0) busy[g] = 1'b0;
        end
        if (tx_vld[g] && bz_auto[g] && bz_dly[g] == 0 && bz_hold[g] == 0) bz_dly[g] = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while ((ctrl_busy[g] !== 1'b0 || exp_q[g].size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (ctrl_busy[g] !== 1'b0 || exp_q[g].size() != 0) begin
      errors++;
      $display("FAIL idle inst%0d: CTRL_BUSY=%b unsent=%0d, expected 0 and 0", g, ctrl_busy[g], exp_q[g].size());
    end
  endtask

  task automatic send_rd(input int g, input logic [7:0] d);
    rd_d[g] = d; rd_vld[g] = 1'b1;
    @(negedge clk);
    rd_vld[g] = 1'b0;
  endtask

  task automatic send_alu(input int g, input logic [31:0] v);
    alu[g] = v; alu_vld[g] = 1'b1;
    @(negedge clk);
    alu_vld[g] = 1'b0;
  endtask

  initial begin
    int n;
    int ovf0;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      rd_d[g] = '0; rd_vld[g] = 1'b0; alu[g] = '0; alu_vld[g] = 1'b0; bz_auto[g] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_tx_vld%0d", g), 32'(tx_vld[g]), 0);
      chk($sformatf("rst_tx_in%0d", g), 32'(tx_in[g]), 0);
      chk($sformatf("rst_ctrl_busy%0d", g), 32'(ctrl_busy[g]), 0);
      chk($sformatf("rst_ovf%0d", g), 32'(ovf[g]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // DATA frame with latency check: strobe in the cycle after edge k+2.
    exp_q[0].push_back(8'hA5);
    send_rd(0, 8'hA5);
    chk("lat_k0", 32'(tx_vld[0]), 0);
    @(negedge clk);
    chk("lat_k1", 32'(tx_vld[0]), 0);
    @(negedge clk);
    chk("lat_k2", 32'(tx_vld[0]), 1);
    chk("lat_byte", 32'(tx_in[0]), 32'hA5);
    wait_idle(0);
    chk("data_ovf", 32'(ovf_cnt[0]), 0);

    // ALU 32-bit, LSB first and MSB first.
    exp_q[1] = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_alu(1, 32'h12345678);
    wait_idle(1);
    exp_q[2] = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_alu(2, 32'h12345678);
    wait_idle(2);

    // Collision: DATA wins, ALU follows, nothing dropped.
    exp_q[0] = '{8'h3C, 8'hEF, 8'hBE};
    rd_d[0] = 8'h3C; rd_vld[0] = 1'b1; alu[0] = 32'h0000BEEF; alu_vld[0] = 1'b1;
    @(negedge clk);
    rd_vld[0] = 1'b0; alu_vld[0] = 1'b0;
    wait_idle(0);
    chk("collision_ovf", 32'(ovf_cnt[0]), 0);

    // Overflow: second ALU request during a frame is dropped.
    ovf0 = ovf_cnt[0];
    exp_q[0] = '{8'h5A, 8'h11, 8'h11};
    send_rd(0, 8'h5A);
    repeat (2) @(negedge clk);
    send_alu(0, 32'h00001111);
    repeat (2) @(negedge clk);
    send_alu(0, 32'h00002222);
    wait_idle(0);
    chk("overflow_ovf_cycles", 32'(ovf_cnt[0] - ovf0), 1);

    // Timeout: BUSY held low, re-strobe period of 5, then release.
    bz_auto[0] = 1'b0;
    exp_q[0] = '{8'h77, 8'h77, 8'h77, 8'h77};
    send_rd(0, 8'h77);
    n = 0;
    while (tx_vld[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_first_strobe", 32'(tx_vld[0]), 1);
    for (int p = 0; p < 2; p++) begin
      for (int j = 1; j < 5; j++) begin
        @(negedge clk);
        chk($sformatf("timeout_gap%0d_%0d", p, j), 32'(tx_vld[0]), 0);
      end
      @(negedge clk);
      chk($sformatf("timeout_restrobe%0d", p), 32'(tx_vld[0]), 1);
      chk($sformatf("timeout_byte%0d", p), 32'(tx_in[0]), 32'h77);
    end
    repeat (3) @(negedge clk);
    bz_auto[0] = 1'b1;
    wait_idle(0);

    // Reset during byte 2 of 4.
    exp_q[1] = '{8'h0D, 8'hF0};
    send_alu(1, 32'hCAFEF00D);
    n = 0;
    while (exp_q[1].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reset_reached_byte2", 32'(exp_q[1].size()), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx_vld", 32'(tx_vld[1]), 0);
    chk("midrst_tx_in", 32'(tx_in[1]), 0);
    chk("midrst_ctrl_busy", 32'(ctrl_busy[1]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("postrst_idle", 32'(ctrl_busy[1]), 0);

    // First edge after reset release samples inputs.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q[1].push_back(8'h99);
    send_rd(1, 8'h99);
    wait_idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_ctrl_tx_framer.md
SYS_CTRL_TX_FRAMER -- requirements
Module: sys_ctrl_tx_framer

Interface
REQ-001 The block SHALL have parameter ALU_W, default 16: ALU result width; a multiple of 8 and at least 8; NBYTES = ALU_W/8.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 sends ALU byte 0 (bits 7:0) first; 0 sends the most significant byte first.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: cycles allowed for BUSY to rise after TX_VLD before re-issue; 0 disables retry.
REQ-004 The block SHALL have these ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Rd_D  in  8  register-file read data.
- Rd_D_VLD  in  1  Rd_D valid for one cycle.
- ALU_OUT  in  ALU_W  ALU result.
- ALU_VLD  in  1  ALU_OUT valid for one cycle.
- BUSY  in  1  UART TX busy, synchronous to CLK.
- TX_VLD  out  1  one-cycle byte-valid strobe to the UART TX.
- TX_IN  out  8  byte to transmit.
- CTRL_BUSY  out  1  high whenever state is not IDLE or any request is pending.
- OVF  out  1  one-cycle pulse when an incoming request is dropped.

Function
REQ-005 Each source (DATA, ALU) SHALL have a one-deep holding register plus pending flag, captured on the CLK edge where its VLD is high; Rd_D_VLD and ALU_VLD together SHALL capture both, with none lost.
REQ-006 A VLD arriving while that source is pending and not being consumed on the same edge SHALL be dropped, keep the old entry, and pulse OVF high for the following cycle.
REQ-007 Consume and capture on the same edge SHALL leave the pending flag set, holding the new value.
REQ-008 Arbitration in IDLE SHALL be fixed: DATA before ALU.
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-010 IDLE with a request pending SHALL load the shift register and byte counter (1 for DATA, NBYTES for ALU), clear the pending flag, and go to ISSUE.
REQ-011 ISSUE SHALL last one cycle with TX_VLD=1 and TX_IN equal to the current byte, then go to WAIT_HI.
REQ-012 WAIT_HI SHALL go to WAIT_LO on BUSY=1; while BUSY=0 its wait counter SHALL increment, and on reaching TIMEOUT-1 (TIMEOUT>0) the FSM SHALL return to ISSUE with the same byte.
REQ-013 WAIT_LO on BUSY=0 SHALL: if the counter is >1, decrement it, shift to the next byte per LSB_FIRST, and go to ISSUE; otherwise go to IDLE.
REQ-014 TX_VLD and TX_IN SHALL be registered; TX_IN SHALL hold its last byte outside ISSUE; TX_VLD SHALL be 0 in every state other than ISSUE.
REQ-015 Latency: a request sampled at edge k with the FSM idle and nothing pending SHALL produce TX_VLD=1 in the cycle following edge k+2.
REQ-016 Back-to-back frames SHALL be gap-free: WAIT_LO->IDLE->ISSUE with the next request already pending.
REQ-017 ALU_W=8 SHALL behave identically to DATA framing (one byte).

Reset
REQ-018 While RST=1, the block SHALL asynchronously force state=IDLE, all pending flags=0, the counter and shift register=0, TX_VLD=0, TX_IN=0x00, CTRL_BUSY=0, and OVF=0.
REQ-019 Reset mid-frame SHALL discard the frame and all pending requests; the first rising edge after RST falls SHALL sample inputs normally.

Structure
REQ-020 Package sys_ctrl_pkg SHALL hold the state encoding, the BYTE_W=8 constant, and the NBYTES/counter-width helper functions.
REQ-021 The holding register plus pending flag SHALL be sub-module sys_ctrl_req_hold, parametrised by width and instantiated twice.
REQ-022 All state and data registers SHALL be clocked by CLK only; no latches SHALL be inferred.

Verification
REQ-023 Scenario DATA: Rd_D=0xA5 pulse, BUSY model rising 2 cycles after TX_VLD and high 10 cycles -> a single TX_VLD with TX_IN=0xA5, then IDLE with CTRL_BUSY=0.
REQ-024 Scenario ALU: ALU_W=32, LSB_FIRST=1, ALU_OUT=0x12345678 -> bytes 0x78, 0x56, 0x34, 0x12, each issued only after BUSY falls; with LSB_FIRST=0 -> 0x12, 0x34, 0x56, 0x78.
REQ-025 Scenario collision: Rd_D=0x3C and ALU_OUT=0xBEEF in the same cycle -> 0x3C, then 0xEF, then 0xBE; OVF stays 0.
REQ-026 Scenario overflow: while a frame is in progress, two ALU_VLD pulses (0x1111 then 0x2222) -> a single OVF pulse, and 0x1111 is sent afterwards while 0x2222 is not.
REQ-027 Scenario timeout: BUSY held 0, TIMEOUT=4 -> TX_VLD re-pulses every 5 cycles with the same TX_IN; on releasing BUSY the frame completes normally.
REQ-028 Scenario reset: RST asserted during byte 2 of 4 -> TX_VLD=0 and TX_IN=0x00 immediately; after release, nothing is sent until a new VLD.
